internal_memory_arbiter: RTL and testbench

- Four-requester round-robin arbiter in front of the 512 KB internal memory (64K x 64-bit words, byte-enabled, one-cycle registered read).
- Accepts one request per cycle and drives a single registered command to the memory.
- Extends the memory tag with the requester index so read data can be routed back.
- Returns read data to the issuing requester with fixed latency.

---
 rtl/internal_memory_arbiter_if.sv | 35 +++
 rtl/internal_memory_arbiter.sv | 108 ++++++++++
 tb/tb_internal_memory_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/internal_memory_arbiter_if.sv
// Requester-side and memory-side signals of the internal memory arbiter.
// The master modport is the environment view; slave is the arbiter's view.
interface internal_memory_arbiter_if #(
  parameter int unsigned TagWidth = 21
) ();
  logic [3:0]                   ACT;
  logic [3:0]                   CMD;
  logic [3:0][15:0]             ADDR;
  logic [3:0][7:0]              BE;
  logic [3:0][63:0]             DI;
  logic [3:0][TagWidth-1:0]     TI;
  logic [3:0]                   NEXT;
  logic [3:0]                   DRDY;
  logic [63:0]                  DO;
  logic [TagWidth-1:0]          TO;
  logic                         MACT;
  logic                         MCMD;
  logic [15:0]                  MADDR;
  logic [7:0]                   MBE;
  logic [63:0]                  MDI;
  logic [TagWidth+1:0]          MTI;
  logic                         MDRDY;
  logic [63:0]                  MDO;
  logic [TagWidth+1:0]          MTO;

  modport master (
    output ACT, CMD, ADDR, BE, DI, TI, MDRDY, MDO, MTO,
    input  NEXT, DRDY, DO, TO, MACT, MCMD, MADDR, MBE, MDI, MTI
  );

  modport slave (
    input  ACT, CMD, ADDR, BE, DI, TI, MDRDY, MDO, MTO,
    output NEXT, DRDY, DO, TO, MACT, MCMD, MADDR, MBE, MDI, MTI
  );
endinterface

// File: rtl/internal_memory_arbiter.sv
// Four-requester round-robin arbiter driving one registered memory command per cycle
// and routing read data back to the issuer via the requester index carried in the tag.
module internal_memory_arbiter #(
  parameter int unsigned TagWidth = 21
) (
  input  logic                          CLK,
  input  logic                          RESET,
  internal_memory_arbiter_if.slave      bus_io
);

  logic [1:0]          ptr_q, ptr_d;
  logic                grant_valid;
  logic [1:0]          grant_idx;
  logic [1:0]          cand_idx;

  logic                mact_q, mact_d;
  logic                mcmd_q, mcmd_d;
  logic [15:0]         maddr_q, maddr_d;
  logic [7:0]          mbe_q, mbe_d;
  logic [63:0]         mdi_q, mdi_d;
  logic [TagWidth+1:0] mti_q, mti_d;

  logic [3:0]          drdy_q, drdy_d;
  logic [63:0]         rdata_q, rdata_d;
  logic [TagWidth-1:0] rtag_q, rtag_d;

  // Scan offsets high to low so the requester closest to the pointer wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr_q;
    cand_idx    = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand_idx = ptr_q + 2'(k);
      if (RESET && bus_io.ACT[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    mact_d  = grant_valid;
    mcmd_d  = mcmd_q;
    maddr_d = maddr_q;
    mbe_d   = mbe_q;
    mdi_d   = mdi_q;
    mti_d   = mti_q;
    if (grant_valid) begin
      ptr_d   = grant_idx + 2'd1;
      mcmd_d  = bus_io.CMD[grant_idx];
      maddr_d = bus_io.ADDR[grant_idx];
      mbe_d   = bus_io.BE[grant_idx];
      mdi_d   = bus_io.DI[grant_idx];
      mti_d   = {grant_idx, bus_io.TI[grant_idx]};
    end
  end

  // Top two tag bits select which requester sees the returned data.
  always_comb begin
    drdy_d  = 4'b0000;
    rdata_d = rdata_q;
    rtag_d  = rtag_q;
    if (bus_io.MDRDY) begin
      drdy_d  = 4'b0001 << bus_io.MTO[TagWidth+1 -: 2];
      rdata_d = bus_io.MDO;
      rtag_d  = bus_io.MTO[TagWidth-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ptr_q   <= 2'd0;
      mact_q  <= 1'b0;
      mcmd_q  <= 1'b0;
      maddr_q <= '0;
      mbe_q   <= 8'hFF;
      mdi_q   <= '0;
      mti_q   <= '0;
      drdy_q  <= 4'b0000;
      rdata_q <= '0;
      rtag_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      mact_q  <= mact_d;
      mcmd_q  <= mcmd_d;
      maddr_q <= maddr_d;
      mbe_q   <= mbe_d;
      mdi_q   <= mdi_d;
      mti_q   <= mti_d;
      drdy_q  <= drdy_d;
      rdata_q <= rdata_d;
      rtag_q  <= rtag_d;
    end
  end

  assign bus_io.NEXT  = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;
  assign bus_io.MACT  = mact_q;
  assign bus_io.MCMD  = mcmd_q;
  assign bus_io.MADDR = maddr_q;
  assign bus_io.MBE   = mbe_q;
  assign bus_io.MDI   = mdi_q;
  assign bus_io.MTI   = mti_q;
  assign bus_io.DRDY  = drdy_q;
  assign bus_io.DO    = rdata_q;
  assign bus_io.TO    = rtag_q;

endmodule

// File: tb/tb_internal_memory_arbiter.sv
// Directed bench: reference arbiter/memory model with a read-return scoreboard,
// checked every cycle against the arbiter outputs.
module tb_internal_memory_arbiter;
  localparam int unsigned TW = 21;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  internal_memory_arbiter_if #(.TagWidth(TW)) bus ();

  internal_memory_arbiter #(.TagWidth(TW)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus_io(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]    drdy;
    logic [63:0]   data;
    logic [TW-1:0] tag;
    int            due;
  } exp_t;
  exp_t sbq[$];

  // Bench-side expectations of the registered command stage.
  logic [1:0]    ptr_m;
  logic          e_mact, e_mcmd;
  logic [15:0]   e_maddr;
  logic [7:0]    e_mbe;
  logic [63:0]   e_mdi;
  logic [TW+1:0] e_mti;
  logic [63:0]   refmem [logic [15:0]];

  function automatic logic [63:0] dflt(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, 16'hC3A5};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] di,
                                        input logic [7:0] be);
    logic [63:0] w;
    w = old;
    for (int b = 0; b < 8; b++) if (!be[b]) w[b*8 +: 8] = di[b*8 +: 8];
    return w;
  endfunction

  // Memory model: registered one-cycle read, byte-enabled write.
  logic [63:0] mem [65536];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = dflt(16'(i));
    forever begin
      @(posedge clk);
      bus.MDRDY <= bus.MACT && bus.MCMD;
      bus.MTO   <= bus.MTI;
      bus.MDO   <= mem[bus.MADDR];
      if (bus.MACT && !bus.MCMD) mem[bus.MADDR] <= merge(mem[bus.MADDR], bus.MDI, bus.MBE);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle();
    bus.ACT = 4'b0000;
  endtask

  task automatic req(input int i, input logic cmd, input logic [15:0] a, input logic [7:0] be,
                     input logic [63:0] di, input logic [TW-1:0] ti);
    bus.ACT[i]  = 1'b1;
    bus.CMD[i]  = cmd;
    bus.ADDR[i] = a;
    bus.BE[i]   = be;
    bus.DI[i]   = di;
    bus.TI[i]   = ti;
  endtask

  // Check one cycle against the model, then advance the model and the clock.
  task automatic cycle();
    logic [3:0]  e_next;
    logic [1:0]  gi, idx;
    logic        gv;
    logic [63:0] rd;
    exp_t        e;
    #1;
    gv = 1'b0;
    gi = 2'd0;
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr_m + 2'(k);
        if (!gv && bus.ACT[idx]) begin
          gv = 1'b1;
          gi = idx;
        end
      end
    end
    e_next = gv ? (4'b0001 << gi) : 4'b0000;
    chk("next",  64'(bus.NEXT),  64'(e_next));
    chk("mact",  64'(bus.MACT),  64'(e_mact));
    chk("mcmd",  64'(bus.MCMD),  64'(e_mcmd));
    chk("maddr", 64'(bus.MADDR), 64'(e_maddr));
    chk("mbe",   64'(bus.MBE),   64'(e_mbe));
    chk("mdi",   bus.MDI,        e_mdi);
    chk("mti",   64'(bus.MTI),   64'(e_mti));
    if (sbq.size() != 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("drdy", 64'(bus.DRDY), 64'(e.drdy));
      chk("do",   bus.DO,        e.data);
      chk("to",   64'(bus.TO),   64'(e.tag));
    end else begin
      chk("drdy_idle", 64'(bus.DRDY), 64'd0);
    end

    if (!rst_n) begin
      ptr_m   = 2'd0;
      e_mact  = 1'b0;
      e_mcmd  = 1'b0;
      e_maddr = '0;
      e_mbe   = 8'hFF;
      e_mdi   = '0;
      e_mti   = '0;
      sbq.delete();
    end else begin
      e_mact = gv;
      if (gv) begin
        ptr_m   = gi + 2'd1;
        e_mcmd  = bus.CMD[gi];
        e_maddr = bus.ADDR[gi];
        e_mbe   = bus.BE[gi];
        e_mdi   = bus.DI[gi];
        e_mti   = {gi, bus.TI[gi]};
        rd = refmem.exists(bus.ADDR[gi]) ? refmem[bus.ADDR[gi]] : dflt(bus.ADDR[gi]);
        if (bus.CMD[gi]) sbq.push_back('{4'b0001 << gi, rd, bus.TI[gi], cyc + 3});
        else refmem[bus.ADDR[gi]] = merge(rd, bus.DI[gi], bus.BE[gi]);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.ACT  = 4'b0000;
    bus.CMD  = '0;
    bus.ADDR = '0;
    bus.BE   = '1;
    bus.DI   = '0;
    bus.TI   = '0;
    ptr_m = 2'd0; e_mact = 1'b0; e_mcmd = 1'b0; e_maddr = '0;
    e_mbe = 8'hFF; e_mdi = '0; e_mti = '0;
    repeat (2) @(negedge clk);

    // Reset state, with all requests active to show NEXT is held off.
    for (int i = 0; i < 4; i++) req(i, 1'b1, 16'(i), 8'hFF, 64'd0, TW'(i));
    repeat (2) cycle();
    chk("do_reset", bus.DO, 64'd0);
    chk("to_reset", 64'(bus.TO), 64'd0);
    idle();
    rst_n = 1'b1;
    cycle();

    // Single read from requester 2.
    req(2, 1'b1, 16'h0010, 8'hFF, 64'd0, TW'(5));
    cycle();
    idle();
    repeat (4) cycle();

    // Write / read-back, then partial byte write / read-back.
    req(0, 1'b0, 16'hFFFF, 8'h00, 64'h1122334455667788, TW'(0));
    cycle(); idle();
    req(1, 1'b1, 16'hFFFF, 8'hFF, 64'd0, TW'(7));
    cycle(); idle();
    req(0, 1'b0, 16'hFFFF, 8'hFE, 64'd0, TW'(1));
    cycle(); idle();
    req(1, 1'b1, 16'hFFFF, 8'hFF, 64'd0, TW'(8));
    cycle(); idle();
    repeat (4) cycle();
    chk("wr_ref_a", refmem[16'hFFFF], 64'h1122334455667700);

    // Streaming reads from requester 3.
    for (int t = 0; t < 4; t++) begin
      idle();
      req(3, 1'b1, 16'h0100 + 16'(t), 8'hFF, 64'd0, TW'(t));
      cycle();
    end
    idle();
    repeat (4) cycle();

    // Reset one cycle after a read grant; the read must never return.
    req(1, 1'b1, 16'h0042, 8'hFF, 64'd0, TW'(9));
    cycle();
    for (int i = 0; i < 4; i++) req(i, 1'b1, 16'h0200 + 16'(i), 8'hFF, 64'd0, TW'(16 + i));
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;

    // Full contention from a reset pointer.
    repeat (8) cycle();

    // Rotation skip: pointer to 1, then ACT=1001.
    idle();
    req(0, 1'b1, 16'h0300, 8'hFF, 64'd0, TW'(30));
    cycle();
    idle();
    req(0, 1'b1, 16'h0301, 8'hFF, 64'd0, TW'(31));
    req(3, 1'b1, 16'h0302, 8'hFF, 64'd0, TW'(32));
    repeat (2) cycle();
    idle();
    repeat (5) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d observed=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
